// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst master: FSM states, mode bit
// positions within the 2-bit {CPOL,CPHA} field, and default sizes.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Bit positions inside the mode field.
    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_CLK_DIV = 2;
    localparam int DEFAULT_LEN_W   = 4;

    // Width of a counter that must hold the values 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides the system clock by CLK_DIV per half-period while
// enabled and flags the leading/trailing SCLK edges one cycle ahead, so the
// shifter acts on the same system clock edge that moves SCLK.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic cpol,
    output logic sclk,
    output logic lead,
    output logic trail
);

    localparam int CW = cnt_w(CLK_DIV);

    logic [CW-1:0] div_cnt;
    logic          phase;   // 0: SCLK at idle level, 1: SCLK at active level
    logic          tick;

    assign tick = en && (div_cnt == CW'(CLK_DIV - 1));

    // Half-period divider and SCLK phase; parked at the idle level when disabled.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || !en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // SCLK follows the latched polarity immediately, so a new CPOL shows in LOAD.
    assign sclk  = cpol ^ phase;
    assign lead  = tick && !phase;
    assign trail = tick && phase;

endmodule

// File: rtl/spi_burst_master.sv
// SPI master that moves a burst of i_len words under one chip-select frame.
// Words are taken from a valid/ready stream, shifted MSB first in any of the
// four SPI modes, and each received word is returned with a one-cycle strobe.
module spi_burst_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int LEN_W   = DEFAULT_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_mode,
    output logic              o_busy,
    output logic              o_done,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_sclk,
    output logic              o_copi,
    input  logic              i_cipo,
    output logic              o_csn
);

    localparam int BW = cnt_w(DATA_W);
    localparam int CW = cnt_w(CLK_DIV);

    state_t            state, state_nxt;
    logic [1:0]        mode;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BW-1:0]     bit_cnt;     // trailing edges seen in the current word
    logic [CW-1:0]     wait_cnt;    // HOLD / GAP dwell timer

    logic cpol, cpha;
    logic lead, trail;
    logic start_ok, handshake, word_done, wait_last;
    logic shift_tx, sample_rx;

    assign cpol = mode[MODE_CPOL];
    assign cpha = mode[MODE_CPHA];

    assign start_ok  = (state == IDLE) && i_start && (i_len != '0);
    assign handshake = (state == LOAD) && i_tx_valid;
    assign word_done = trail && (bit_cnt == BW'(DATA_W - 1));
    assign wait_last = (wait_cnt == CW'(CLK_DIV - 1));

    // CPHA=0 launches on trailing edges (the MSB is already out from LOAD) and
    // must not shift after the last bit; CPHA=1 launches on leading edges, but
    // the first leading edge would discard the MSB presented at LOAD.
    assign shift_tx  = cpha ? (lead && (bit_cnt != '0))
                            : (trail && (bit_cnt != BW'(DATA_W - 1)));
    assign sample_rx = cpha ? trail : lead;

    assign o_copi = tx_sr[DATA_W-1];

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clock (clock),
        .reset (reset),
        .en    (state == SHIFT),
        .cpol  (cpol),
        .sclk  (o_sclk),
        .lead  (lead),
        .trail (trail)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        o_tx_ready = 1'b0;
        o_busy     = 1'b1;
        o_csn      = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                o_csn  = 1'b1;
                if (start_ok) state_nxt = LOAD;
            end
            LOAD: begin
                o_tx_ready = 1'b1;
                if (i_tx_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (word_done) state_nxt = (remaining == LEN_W'(1)) ? HOLD : LOAD;
            end
            HOLD: begin
                if (wait_last) state_nxt = GAP;
            end
            GAP: begin
                o_csn = 1'b1;
                if (wait_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst parameters: mode and word count are captured only at an accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode      <= 2'b00;
            remaining <= '0;
        end else if (start_ok) begin
            mode      <= i_mode;
            remaining <= i_len;
        end else if (word_done) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Transmit shift register: loads on handshake, then shifts MSB first.
    always_ff @(posedge clock) begin
        if (reset)         tx_sr <= '0;
        else if (handshake) tx_sr <= i_tx_data;
        else if (shift_tx)  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    end

    // Receive shift register and per-word bit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (handshake) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            if (sample_rx) rx_sr <= {rx_sr[DATA_W-2:0], i_cipo};
            if (trail)     bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
        end
    end

    // Received word output; for CPHA=1 the last bit arrives on the final edge itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= word_done;
            if (word_done) o_rx_data <= cpha ? {rx_sr[DATA_W-2:0], i_cipo} : rx_sr;
        end
    end

    // Dwell timer for HOLD and GAP, plus the end-of-burst pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= (state == GAP) && wait_last;
            if ((state == HOLD || state == GAP) && !wait_last) wait_cnt <= wait_cnt + CW'(1);
            else                                               wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_spi_burst_master.sv
// Scenario bench for spi_burst_master: expected receive words go into a
// queue when each transmit word is handed over and are compared when the
// DUT strobes o_rx_valid; a passive monitor counts SCLK/CSN events.
module tb_spi_burst_master;

    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              i_start = 1'b0;
    logic [LEN_W-1:0]  i_len = '0;
    logic [1:0]        i_mode = 2'b00;
    logic              o_busy, o_done;
    logic [DATA_W-1:0] i_tx_data = '0;
    logic              i_tx_valid = 1'b0;
    logic              o_tx_ready;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              o_sclk, o_copi, i_cipo, o_csn;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  tx_words[4];
    logic [23:0] slave_word = 24'h0;
    bit          loopback = 1'b1;

    // Monitor counters (written only by the monitor process).
    int   cyc = 0, rise_tot = 0, fall_tot = 0, csn_rise_tot = 0;
    int   done_tot = 0, rxv_tot = 0, copi_bad_tot = 0;
    int   last_rise = 0, last_period = 0, slv_idx = 0;
    logic prev_sclk = 1'b0, prev_copi = 1'b0, prev_csn = 1'b1, hs_q = 1'b0;

    spi_burst_master #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_start    (i_start),
        .i_len      (i_len),
        .i_mode     (i_mode),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .i_tx_data  (i_tx_data),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .o_sclk     (o_sclk),
        .o_copi     (o_copi),
        .i_cipo     (i_cipo),
        .o_csn      (o_csn)
    );

    always #5 clock = ~clock;

    // Slave side: either loop COPI back or play slave_word MSB first, advancing on SCLK falls.
    always_comb begin
        if (loopback)          i_cipo = o_copi;
        else if (slv_idx < 24) i_cipo = slave_word[23 - slv_idx];
        else                   i_cipo = 1'b0;
    end

    // Remember whether a word was handed over at this clock edge.
    always @(posedge clock) hs_q <= o_tx_ready && i_tx_valid;

    // Passive monitor sampling on the falling system clock edge.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (!prev_sclk && o_sclk) begin
            rise_tot    <= rise_tot + 1;
            last_period <= cyc - last_rise;
            last_rise   <= cyc;
        end
        if (prev_sclk && !o_sclk) fall_tot <= fall_tot + 1;
        if (!prev_csn && o_csn)   csn_rise_tot <= csn_rise_tot + 1;
        if (o_done)               done_tot <= done_tot + 1;
        if (o_rx_valid)           rxv_tot <= rxv_tot + 1;
        if (!o_csn && (o_copi !== prev_copi) && !(prev_sclk && !o_sclk) && !hs_q)
            copi_bad_tot <= copi_bad_tot + 1;
        if (o_csn)                                        slv_idx <= 0;
        else if (!prev_csn && prev_sclk && !o_sclk)       slv_idx <= slv_idx + 1;
        prev_sclk <= o_sclk;
        prev_copi <= o_copi;
        prev_csn  <= o_csn;
    end

    // Issue a start and confirm the frame opens on the next cycle at the new idle polarity.
    task automatic start_burst(input int len, input logic [1:0] mode);
        @(negedge clock);
        i_len   = LEN_W'(len);
        i_mode  = mode;
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        i_len   = '0;
        tests_run++;
        if (o_busy !== 1'b1 || o_csn !== 1'b0 || o_sclk !== mode[1]) begin
            tests_failed++;
            $display("FAIL start_frame: busy=%b csn=%b sclk=%b, required busy=1 csn=0 sclk=%b",
                     o_busy, o_csn, o_sclk, mode[1]);
        end
    endtask

    // Feed tx_words, score received words, and wait for o_done within a cycle budget.
    task automatic finish_burst(input int len, input logic [1:0] mode, input int stall_word,
                                input int stall_cycles, output int rxv_seen, output int done_seen);
        int         idx = 0;
        int         stalled = 0;
        int         stall_bad = 0;
        int         budget = 0;
        bit         finished = 1'b0;
        logic [7:0] exp;
        rxv_seen  = 0;
        done_seen = 0;
        while (!finished && budget < 3000) begin
            if (o_rx_valid) begin
                rxv_seen++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rx_unexpected: got %h, no word was pending", o_rx_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_rx_data !== exp) begin
                        tests_failed++;
                        $display("FAIL rx_word: got %h, required %h", o_rx_data, exp);
                    end
                end
            end
            if (o_done) begin
                done_seen++;
                finished = 1'b1;
                tests_run++;
                if (o_busy !== 1'b0 || o_rx_valid !== 1'b0 || o_csn !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL done_cycle: busy=%b rx_valid=%b csn=%b, required 0 0 1",
                             o_busy, o_rx_valid, o_csn);
                end
            end
            if (!finished && o_tx_ready && idx < len) begin
                if (idx == stall_word && stalled < stall_cycles) begin
                    stalled++;
                    i_tx_valid = 1'b0;
                    if (o_sclk !== mode[1] || o_csn !== 1'b0) stall_bad++;
                end else begin
                    i_tx_valid = 1'b1;
                    i_tx_data  = tx_words[idx];
                    exp_q.push_back(loopback ? tx_words[idx] : slave_word[(23 - 8*idx) -: 8]);
                    idx++;
                end
            end else begin
                i_tx_valid = 1'b0;
            end
            if (!finished) begin
                @(negedge clock);
                budget++;
            end
        end
        i_tx_valid = 1'b0;
        if (!finished) begin
            tests_run++;
            tests_failed++;
            $display("FAIL burst_timeout: no o_done after %0d cycles, required completion", budget);
        end
        if (stall_cycles > 0) begin
            tests_run++;
            if (stall_bad !== 0 || stalled !== stall_cycles) begin
                tests_failed++;
                $display("FAIL load_stall: bad_cycles=%0d stalled=%0d, required 0 and %0d",
                         stall_bad, stalled, stall_cycles);
            end
        end
        @(negedge clock);
        tests_run++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_csn !== 1'b1 || o_sclk !== mode[1]) begin
            tests_failed++;
            $display("FAIL after_done: done=%b busy=%b csn=%b sclk=%b, required 0 0 1 %b",
                     o_done, o_busy, o_csn, o_sclk, mode[1]);
        end
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL rx_missing: %0d words never received, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if (o_csn !== 1'b1 || o_sclk !== 1'b0 || o_copi !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_lines: csn=%b sclk=%b copi=%b busy=%b, required 1 0 0 0",
                     o_csn, o_sclk, o_copi, o_busy);
        end
        tests_run++;
        if (o_done !== 1'b0 || o_tx_ready !== 1'b0 || o_rx_valid !== 1'b0 || o_rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_status: done=%b ready=%b rx_valid=%b rx_data=%h, required 0 0 0 00",
                     o_done, o_tx_ready, o_rx_valid, o_rx_data);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mode0_loopback();
        int rxv, dn, r0, c0;
        loopback    = 1'b1;
        tx_words[0] = 8'hA5;
        r0 = rise_tot;
        c0 = copi_bad_tot;
        start_burst(1, 2'b00);
        finish_burst(1, 2'b00, -1, 0, rxv, dn);
        tests_run++;
        if (rxv !== 1 || dn !== 1) begin
            tests_failed++;
            $display("FAIL m0_counts: rx_valid=%0d done=%0d, required 1 1", rxv, dn);
        end
        tests_run++;
        if (rise_tot - r0 !== 8 || last_period !== 2*CLK_DIV) begin
            tests_failed++;
            $display("FAIL m0_sclk: rises=%0d period=%0d, required 8 %0d", rise_tot - r0, last_period, 2*CLK_DIV);
        end
        tests_run++;
        if (copi_bad_tot !== c0 || o_rx_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL m0_hold: copi_off_edge=%0d rx_data=%h, required 0 a5", copi_bad_tot - c0, o_rx_data);
        end
    endtask

    task automatic test_burst3();
        int rxv, dn, r0, s0;
        loopback    = 1'b0;
        slave_word  = 24'h00005C;
        tx_words[0] = 8'h0B;
        tx_words[1] = 8'h0E;
        tx_words[2] = 8'h00;
        r0 = rise_tot;
        s0 = csn_rise_tot;
        start_burst(3, 2'b00);
        finish_burst(3, 2'b00, -1, 0, rxv, dn);
        tests_run++;
        if (rxv !== 3 || dn !== 1) begin
            tests_failed++;
            $display("FAIL b3_counts: rx_valid=%0d done=%0d, required 3 1", rxv, dn);
        end
        tests_run++;
        if (rise_tot - r0 !== 24 || csn_rise_tot - s0 !== 1) begin
            tests_failed++;
            $display("FAIL b3_frame: rises=%0d csn_rises=%0d, required 24 1", rise_tot - r0, csn_rise_tot - s0);
        end
        loopback = 1'b1;
    endtask

    task automatic test_modes_cpha1();
        int rxv, dn, c0;
        loopback    = 1'b1;
        tx_words[0] = 8'h3C;
        c0 = copi_bad_tot;
        start_burst(1, 2'b11);
        finish_burst(1, 2'b11, -1, 0, rxv, dn);
        tests_run++;
        if (rxv !== 1 || dn !== 1 || copi_bad_tot !== c0) begin
            tests_failed++;
            $display("FAIL m3: rx_valid=%0d done=%0d copi_off_edge=%0d, required 1 1 0",
                     rxv, dn, copi_bad_tot - c0);
        end
        tx_words[0] = 8'hE7;
        start_burst(1, 2'b01);
        finish_burst(1, 2'b01, -1, 0, rxv, dn);
        tests_run++;
        if (rxv !== 1 || dn !== 1) begin
            tests_failed++;
            $display("FAIL m1: rx_valid=%0d done=%0d, required 1 1", rxv, dn);
        end
    endtask

    task automatic test_stall();
        int rxv, dn;
        loopback    = 1'b1;
        tx_words[0] = 8'h96;
        tx_words[1] = 8'h69;
        start_burst(2, 2'b00);
        finish_burst(2, 2'b00, 1, 50, rxv, dn);
        tests_run++;
        if (rxv !== 2 || dn !== 1) begin
            tests_failed++;
            $display("FAIL stall_counts: rx_valid=%0d done=%0d, required 2 1", rxv, dn);
        end
    endtask

    task automatic test_reset_mid();
        int   edges = 0;
        int   budget = 0;
        bit   fed = 1'b0;
        logic prev;
        int   d0, v0, rxv, dn;
        loopback    = 1'b1;
        tx_words[0] = 8'hC3;
        start_burst(2, 2'b00);
        prev = o_sclk;
        while (edges < 5 && budget < 500) begin
            if (o_tx_ready && !fed) begin
                i_tx_valid = 1'b1;
                i_tx_data  = tx_words[0];
                fed = 1'b1;
            end else begin
                i_tx_valid = 1'b0;
            end
            @(negedge clock);
            budget++;
            if (o_sclk !== prev) edges++;
            prev = o_sclk;
        end
        i_tx_valid = 1'b0;
        tests_run++;
        if (edges < 5) begin
            tests_failed++;
            $display("FAIL rst_mid_edges: saw %0d SCLK edges, required 5", edges);
        end
        d0 = done_tot;
        v0 = rxv_tot;
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (o_csn !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_rx_valid !== 1'b0 || o_rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid_abort: csn=%b busy=%b done=%b rx_valid=%b rx_data=%h, required 1 0 0 0 00",
                     o_csn, o_busy, o_done, o_rx_valid, o_rx_data);
        end
        reset = 1'b0;
        repeat (40) @(negedge clock);
        tests_run++;
        if (done_tot !== d0 || rxv_tot !== v0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: done=%0d rx_valid=%0d after abort, required 0 0",
                     done_tot - d0, rxv_tot - v0);
        end
        tx_words[0] = 8'h5A;
        start_burst(1, 2'b00);
        finish_burst(1, 2'b00, -1, 0, rxv, dn);
        tests_run++;
        if (rxv !== 1 || dn !== 1) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: rx_valid=%0d done=%0d, required 1 1", rxv, dn);
        end
    endtask

    task automatic test_ignored_start();
        int rxv, dn;
        @(negedge clock);
        i_start = 1'b1;
        i_len   = '0;
        i_mode  = 2'b11;
        repeat (2) @(negedge clock);
        i_start = 1'b0;
        tests_run++;
        if (o_busy !== 1'b0 || o_csn !== 1'b1 || o_tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len: busy=%b csn=%b ready=%b, required 0 1 0", o_busy, o_csn, o_tx_ready);
        end
        loopback    = 1'b1;
        tx_words[0] = 8'h81;
        start_burst(1, 2'b00);
        i_start    = 1'b1;
        i_len      = LEN_W'(3);
        i_mode     = 2'b11;
        i_tx_valid = 1'b0;
        @(negedge clock);
        i_start = 1'b0;
        i_len   = '0;
        tests_run++;
        if (o_csn !== 1'b0 || o_sclk !== 1'b0 || o_tx_ready !== 1'b1 || o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start: csn=%b sclk=%b ready=%b busy=%b, required 0 0 1 1",
                     o_csn, o_sclk, o_tx_ready, o_busy);
        end
        finish_burst(1, 2'b00, -1, 0, rxv, dn);
        tests_run++;
        if (rxv !== 1 || dn !== 1) begin
            tests_failed++;
            $display("FAIL busy_start_len: rx_valid=%0d done=%0d, required 1 1", rxv, dn);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_mode0_loopback();
        test_burst3();
        test_modes_cpha1();
        test_stall();
        test_reset_mid();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit in case a scenario loop is ever left unbounded.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required scenarios to finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_burst_master.md
SPI_BURST_MASTER -- requirements
Module: spi_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per SPI word, legal 4..32.
REQ-002 SHALL have parameter CLK_DIV, default 2: system clocks per SCLK half-period, legal >=2.
REQ-003 SHALL have parameter LEN_W, default 4: width of burst-length field (max 2^LEN_W-1 words).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: clock in 1 system clock; reset in 1 sync active-high reset.
REQ-006 SHALL have ports: i_start in 1 burst request; i_len in LEN_W words in burst; i_mode in 2 {CPOL,CPHA}.
REQ-007 SHALL have ports: o_busy out 1 burst in progress; o_done out 1 one-cycle end-of-burst pulse.
REQ-008 SHALL have ports: i_tx_data in DATA_W; i_tx_valid in 1; o_tx_ready out 1 (word accepted when valid&ready).
REQ-009 SHALL have ports: o_rx_data out DATA_W; o_rx_valid out 1 (one-cycle pulse per received word).
REQ-010 SHALL have ports: o_sclk out 1; o_copi out 1; i_cipo in 1; o_csn out 1 (active low).

Function
REQ-011 SHALL use FSM states IDLE, LOAD, SHIFT, HOLD, GAP.
REQ-012 IDLE: i_start=1 with i_len!=0 SHALL latch i_len and i_mode, drive o_csn=0 and o_busy=1 the next cycle, and enter LOAD; i_start with i_len=0 SHALL be ignored.
REQ-013 i_start while o_busy=1 SHALL be ignored; i_mode SHALL be sampled only at burst start.
REQ-014 o_sclk SHALL idle at latched CPOL whenever not in SHIFT, including LOAD stalls.
REQ-015 LOAD: o_tx_ready=1; on handshake SHALL load the shift register, present the MSB on o_copi in the same cycle the register loads, and enter SHIFT.
REQ-016 LOAD with i_tx_valid=0 SHALL stall indefinitely, o_csn held low.
REQ-017 SHIFT: o_sclk SHALL toggle every CLK_DIV clocks, 2*DATA_W edges per word, first edge CLK_DIV clocks after entering SHIFT.
REQ-018 CPHA=0: SHALL sample i_cipo on leading edges and shift o_copi on trailing edges except after the final bit; CPHA=1: SHALL shift o_copi on leading edges and sample on trailing edges.
REQ-019 Data SHALL be MSB first on both lines.
REQ-020 After the last edge of a word, o_rx_data SHALL update and o_rx_valid SHALL pulse for one cycle; o_rx_data SHALL hold until the next word.
REQ-021 After a word, the FSM SHALL decrement the remaining count: nonzero -> LOAD (o_csn stays 0), zero -> HOLD.
REQ-022 HOLD SHALL keep o_csn=0 for CLK_DIV clocks, then raise o_csn and enter GAP.
REQ-023 GAP SHALL keep o_csn=1 for CLK_DIV clocks, then pulse o_done, clear o_busy and return to IDLE in the same cycle.
REQ-024 o_tx_ready SHALL be 0 outside LOAD; o_rx_valid SHALL never coincide with o_done.

Reset
REQ-025 On reset the FSM SHALL go to IDLE, and o_csn=1, o_sclk=0, o_copi=0, o_busy=0, o_done=0, o_tx_ready=0, o_rx_valid=0, o_rx_data=0, counters 0.
REQ-026 Reset mid-burst SHALL abort immediately, with no o_done and no o_rx_valid for the partial word.

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum, the mode bit indices (CPOL=1, CPHA=0) and the default parameter constants.
REQ-028 Sub-module spi_clk_gen SHALL implement the CLK_DIV divider, o_sclk level and lead/trail edge strobes, enabled only in SHIFT.

Verification
REQ-029 Mode 0, CLK_DIV=2, o_copi looped to i_cipo, len=1, tx 0xA5 -> 8 rising edges, SCLK period 4 clocks, o_rx_data=0xA5, one o_done.
REQ-030 Mode 0, len=3, tx 0x0B,0x0E,0x00, slave returns 0x00,0x00,0x5C -> o_csn low continuously for 24 SCLK cycles, rx sequence 0x00,0x00,0x5C, three o_rx_valid pulses then o_done.
REQ-031 Mode 3, len=1, tx 0x3C with loopback -> o_sclk idle high before and after, 0x3C received, COPI changes only on falling edges.
REQ-032 len=2, i_tx_valid withheld 50 clocks before word 2 -> o_sclk frozen at CPOL, o_csn low, burst completes with correct data.
REQ-033 Reset asserted at the 5th SCLK edge of a word -> next cycle o_csn=1, o_busy=0, no o_done or o_rx_valid; a new burst then works.
REQ-034 i_start with i_len=0, and i_start during busy -> no state change, o_csn stays at its current level.
